// File: rtl/ofdm_cp_pingpong_buf_pkg.sv
// ofdm_pkg: shared definitions for the OFDM cyclic-prefix ping-pong buffer.
//
// Contents:
//   LOGN_MIN    smallest supported log2 FFT size
//   rd_state_t  read-side sequencer states (IDLE, RUN)
//   sample_t    one complex sample {x, y} at the default 16-bit width
//   clamp_logn  folds a requested log2 FFT size into LOGN_MIN..logn_max
//   clamp_cp    limits a cyclic-prefix length to the symbol length
package ofdm_pkg;

  localparam int LOGN_MIN = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rd_state_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } sample_t;

  function automatic int clamp_logn(input int logn, input int logn_max);
    if (logn < LOGN_MIN) return LOGN_MIN;
    if (logn > logn_max) return logn_max;
    return logn;
  endfunction

  function automatic int clamp_cp(input int cp, input int n);
    return (cp > n) ? n : cp;
  endfunction

endpackage

// File: rtl/ofdm_cp_pingpong_buf_if.sv
// ofdm_cp_pingpong_buf_if: configuration, write and output buses of the
// cyclic-prefix ping-pong buffer.
//
// Signals:
//   cfg_logn, cfg_cp                 runtime FFT size / prefix length
//   wr_iv, wr_addr, wr_x, wr_y       sample write from the IFFT
//   wr_commit                        closes the current write bank
//   wr_full, wr_ovf                  write-side status
//   oe                               output strobe from the DAC side
//   dox, doy, ov, sos, eos, urun     output sample and framing
//   ready                            at least one bank holds a symbol
//
// Modports: master drives configuration, writes and oe; slave is the buffer.
interface ofdm_cp_pingpong_buf_if
  import ofdm_pkg::*;
#(
  parameter int DW       = 16,
  parameter int LOGN_MAX = 8,
  parameter int CPW      = 8
);

  logic [3:0]          cfg_logn;
  logic [CPW-1:0]      cfg_cp;
  logic                wr_iv;
  logic [LOGN_MAX-1:0] wr_addr;
  logic [DW-1:0]       wr_x;
  logic [DW-1:0]       wr_y;
  logic                wr_commit;
  logic                wr_full;
  logic                wr_ovf;
  logic                oe;
  logic [DW-1:0]       dox;
  logic [DW-1:0]       doy;
  logic                ov;
  logic                sos;
  logic                eos;
  logic                urun;
  logic                ready;

  modport master (
    output cfg_logn, cfg_cp, wr_iv, wr_addr, wr_x, wr_y, wr_commit, oe,
    input  wr_full, wr_ovf, dox, doy, ov, sos, eos, urun, ready
  );

  modport slave (
    input  cfg_logn, cfg_cp, wr_iv, wr_addr, wr_x, wr_y, wr_commit, oe,
    output wr_full, wr_ovf, dox, doy, ov, sos, eos, urun, ready
  );

endinterface

// File: rtl/ofdm_cp_pingpong_buf_dpram.sv
// ofdm_dpram: simple dual-port RAM, one write port and one registered read
// port, both on clk.
//
// Ports:
//   clk, rst        clock; rst clears only the read data register
//   we, waddr, wdata write port
//   re, raddr       read request, data appears on rdata one cycle later
//   rdata           registered read data, held while re is low
module ofdm_dpram
  import ofdm_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register is reset so the output bus is quiet after reset even
  // though the array itself keeps its contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ofdm_cp_pingpong_buf.sv
// ofdm_cp_pingpong_buf: transmit-side OFDM symbol buffer between the IFFT
// and the DAC. Two symbol banks alternate: the IFFT fills one by address
// while the other is streamed in natural order, preceded by a cyclic prefix.
//
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   bus        ofdm_cp_pingpong_buf_if.slave (config, write and output buses)
//   urun_clr   (OFDM_CP_UNDERRUN_CNT_EN only) clears urun_cnt
//   urun_cnt   (OFDM_CP_UNDERRUN_CNT_EN only) saturating count of underrun
//              samples plus rejected commits
//
// Build option: define OFDM_CP_UNDERRUN_CNT_EN to add the underrun counter.
module ofdm_cp_pingpong_buf
  import ofdm_pkg::*;
#(
  parameter int DW       = 16,
  parameter int LOGN_MAX = 8,
  parameter int CPW      = 8
) (
  input  logic clk,
  input  logic rst,
  ofdm_cp_pingpong_buf_if.slave bus
`ifdef OFDM_CP_UNDERRUN_CNT_EN
  ,
  input  logic        urun_clr,
  output logic [15:0] urun_cnt
`endif
);

  // PW holds symbol positions up to 2N-1 plus headroom for N-CP+pos.
  localparam int PW = LOGN_MAX + 2;
  localparam int AW = LOGN_MAX + 1;

  rd_state_t           state;
  logic [1:0]          full;
  logic [1:0]          full_rel;
  logic [1:0]          full_nxt;
  logic                wbank;
  logic                rbank;
  logic [PW-1:0]       pos;
  logic [PW-1:0]       n_lat;
  logic [PW-1:0]       cp_lat;
  logic [CPW-1:0]      cp_in;
  logic [3:0]          logn_cfg;
  logic [PW-1:0]       n_cfg;
  logic [PW-1:0]       cp_cfg;
  logic [PW-1:0]       cur_n;
  logic [PW-1:0]       cur_cp;
  logic                sym_start;
  logic                rd_fire;
  logic                urun_fire;
  logic                last;
  logic                wr_ok;
  logic                commit_ok;
  logic                commit_rej;
  logic [LOGN_MAX-1:0] rd_addr;
  logic [LOGN_MAX-1:0] wr_addr_m;
  logic [2*DW-1:0]     rdata;
  logic                urun_q;

  assign cp_in = bus.cfg_cp;

  // Live configuration, clamped; the write side always uses it, the read
  // side samples it only when a symbol starts.
  always_comb begin
    logn_cfg = 4'(clamp_logn(int'(bus.cfg_logn), LOGN_MAX));
    n_cfg    = PW'(1) << logn_cfg;
    cp_cfg   = PW'(clamp_cp(int'(cp_in), int'(n_cfg)));
  end

  // Read address generation. pos is always 0 in IDLE, so a symbol start is
  // either an IDLE strobe with a full bank or a RUN strobe at pos 0 (the
  // gapless hand-over). The prefix is the tail of the bank, hence the
  // N-CP offset wrapped modulo N.
  always_comb begin
    sym_start = (state == IDLE) ? full[rbank] : (pos == '0);
    rd_fire   = bus.oe && ((state == RUN) || full[rbank]);
    urun_fire = bus.oe && (state == IDLE) && !full[rbank];
    cur_n     = sym_start ? n_cfg  : n_lat;
    cur_cp    = sym_start ? cp_cfg : cp_lat;
    rd_addr   = LOGN_MAX'((cur_n - cur_cp + pos) & (cur_n - PW'(1)));
    last      = rd_fire && (pos == (cur_n + cur_cp - PW'(1)));
  end

  // Bank bookkeeping. Writes are filtered against the bank state at the
  // start of the cycle, while commits see the bank released by a final read
  // in the same cycle, so a writer waiting on a full buffer is not refused.
  always_comb begin
    full_rel = full;
    if (last) full_rel[rbank] = 1'b0;
    wr_ok      = bus.wr_iv && !full[wbank];
    commit_ok  = bus.wr_commit && !full_rel[wbank];
    commit_rej = bus.wr_commit && full_rel[wbank];
    full_nxt   = full_rel;
    if (commit_ok) full_nxt[wbank] = 1'b1;
    wr_addr_m  = bus.wr_addr & LOGN_MAX'(n_cfg - PW'(1));
  end

  // Bank select is the RAM address MSB. A write and a commit in the same
  // cycle both use the pre-toggle wbank, so the sample lands in the bank
  // being closed.
  ofdm_dpram #(
    .WIDTH  (2 * DW),
    .ADDR_W (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr ({wbank, wr_addr_m}),
    .wdata ({bus.wr_x, bus.wr_y}),
    .re    (rd_fire),
    .raddr ({rbank, rd_addr}),
    .rdata (rdata)
  );

  // Read sequencer and registered status. Framing flags are registered
  // alongside the RAM read so they line up with the sample on ov. At the
  // last sample the bank is released and, if the other bank is (or just
  // became) full, the sequencer stays in RUN at pos 0 for a gapless start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      full        <= 2'b00;
      wbank       <= 1'b0;
      rbank       <= 1'b0;
      pos         <= '0;
      n_lat       <= '0;
      cp_lat      <= '0;
      urun_q      <= 1'b0;
      bus.ov      <= 1'b0;
      bus.sos     <= 1'b0;
      bus.eos     <= 1'b0;
      bus.wr_ovf  <= 1'b0;
      bus.wr_full <= 1'b0;
      bus.ready   <= 1'b0;
    end else begin
      full        <= full_nxt;
      bus.wr_full <= &full_nxt;
      bus.ready   <= |full_nxt;
      bus.wr_ovf  <= commit_rej;
      bus.ov      <= bus.oe;
      bus.sos     <= rd_fire && sym_start;
      bus.eos     <= last;
      urun_q      <= urun_fire;
      if (commit_ok) wbank <= ~wbank;
      if (rd_fire) begin
        if (sym_start) begin
          n_lat  <= cur_n;
          cp_lat <= cur_cp;
        end
        if (last) begin
          pos   <= '0;
          rbank <= ~rbank;
          state <= full_nxt[~rbank] ? RUN : IDLE;
        end else begin
          pos   <= pos + PW'(1);
          state <= RUN;
        end
      end
    end
  end

  // An underrun sample is forced to zero rather than replaying stale RAM data.
  assign bus.urun = urun_q;
  assign bus.dox  = urun_q ? '0 : rdata[2*DW-1:DW];
  assign bus.doy  = urun_q ? '0 : rdata[DW-1:0];

`ifdef OFDM_CP_UNDERRUN_CNT_EN
  logic [16:0] cnt_sum;

  assign cnt_sum = {1'b0, urun_cnt} + 17'(urun_fire) + 17'(commit_rej);

  // Underrun samples and rejected commits can coincide, so the step can be
  // two; clear beats any increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           urun_cnt <= '0;
    else if (urun_clr) urun_cnt <= '0;
    else               urun_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_ofdm_cp_pingpong_buf.sv
// tb_ofdm_cp_pingpong_buf: self-checking bench for ofdm_cp_pingpong_buf.
// The reference keeps both banks as arrays and, at every symbol start,
// expands the whole framed symbol (prefix tail + body) into a queue that
// later strobes drain. Build option OFDM_CP_UNDERRUN_CNT_EN adds the
// counter scenario.
module tb_ofdm_cp_pingpong_buf;
  import ofdm_pkg::*;

  localparam int DW       = 16;
  localparam int LOGN_MAX = 8;
  localparam int CPW      = 8;
  localparam int NMAX     = 1 << LOGN_MAX;

  logic clk = 1'b0;
  logic rst;

  ofdm_cp_pingpong_buf_if #(.DW(DW), .LOGN_MAX(LOGN_MAX), .CPW(CPW)) bus ();

`ifdef OFDM_CP_UNDERRUN_CNT_EN
  logic        urun_clr;
  logic [15:0] urun_cnt;
`endif

  ofdm_cp_pingpong_buf #(.DW(DW), .LOGN_MAX(LOGN_MAX), .CPW(CPW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef OFDM_CP_UNDERRUN_CNT_EN
    ,
    .urun_clr (urun_clr),
    .urun_cnt (urun_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem_x [2][NMAX];
  logic [DW-1:0] mem_y [2][NMAX];
  bit            m_full [2];
  int            m_wbank;
  int            m_rbank;
  int            m_cnt;
  sample_t       sym_q [$];

  logic          e_ov, e_sos, e_eos, e_urun, e_full, e_ready, e_ovf;
  logic [DW-1:0] e_dox, e_doy;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full[0] = 1'b0;
    m_full[1] = 1'b0;
    m_wbank   = 0;
    m_rbank   = 0;
    m_cnt     = 0;
    sym_q.delete();
    {e_ov, e_sos, e_eos, e_urun, e_full, e_ready, e_ovf} = '0;
    e_dox = '0;
    e_doy = '0;
  endtask

  // Advances the reference by one clock using the inputs currently driven.
  task automatic model_step();
    bit      fpre [2];
    int      lg, n, cp, a;
    sample_t s;
    fpre[0] = m_full[0];
    fpre[1] = m_full[1];
    lg = int'(bus.cfg_logn);
    if (lg < 5) lg = 5;
    if (lg > LOGN_MAX) lg = LOGN_MAX;
    n  = 1 << lg;
    cp = int'(bus.cfg_cp);
    if (cp > n) cp = n;
    e_ov   = bus.oe;
    e_sos  = 1'b0;
    e_eos  = 1'b0;
    e_urun = 1'b0;
    e_ovf  = 1'b0;
    if (bus.oe) begin
      if (sym_q.size() == 0) begin
        if (m_full[m_rbank]) begin
          for (int i = 0; i < cp; i++) begin
            s.x = mem_x[m_rbank][n - cp + i];
            s.y = mem_y[m_rbank][n - cp + i];
            sym_q.push_back(s);
          end
          for (int i = 0; i < n; i++) begin
            s.x = mem_x[m_rbank][i];
            s.y = mem_y[m_rbank][i];
            sym_q.push_back(s);
          end
          e_sos = 1'b1;
        end else begin
          e_urun = 1'b1;
          e_dox  = '0;
          e_doy  = '0;
        end
      end
      if (!e_urun) begin
        s = sym_q.pop_front();
        e_dox = s.x;
        e_doy = s.y;
        if (sym_q.size() == 0) begin
          e_eos = 1'b1;
          m_full[m_rbank] = 1'b0;
          m_rbank ^= 1;
        end
      end
    end
    if (bus.wr_iv && !fpre[m_wbank]) begin
      a = int'(bus.wr_addr) & (n - 1);
      mem_x[m_wbank][a] = bus.wr_x;
      mem_y[m_wbank][a] = bus.wr_y;
    end
    if (bus.wr_commit) begin
      if (m_full[m_wbank]) e_ovf = 1'b1;
      else begin
        m_full[m_wbank] = 1'b1;
        m_wbank ^= 1;
      end
    end
    e_full  = m_full[0] & m_full[1];
    e_ready = m_full[0] | m_full[1];
`ifdef OFDM_CP_UNDERRUN_CNT_EN
    if (urun_clr) m_cnt = 0;
    else begin
      m_cnt += int'(e_urun) + int'(e_ovf);
      if (m_cnt > 65535) m_cnt = 65535;
    end
`endif
  endtask

  task automatic check_all();
    check_output("ov", 32'(bus.ov), 32'(e_ov));
    check_output("sos", 32'(bus.sos), 32'(e_sos));
    check_output("eos", 32'(bus.eos), 32'(e_eos));
    check_output("urun", 32'(bus.urun), 32'(e_urun));
    check_output("wr_full", 32'(bus.wr_full), 32'(e_full));
    check_output("ready", 32'(bus.ready), 32'(e_ready));
    check_output("wr_ovf", 32'(bus.wr_ovf), 32'(e_ovf));
    if (e_ov) begin
      check_output("dox", 32'(bus.dox), 32'(e_dox));
      check_output("doy", 32'(bus.doy), 32'(e_doy));
    end
`ifdef OFDM_CP_UNDERRUN_CNT_EN
    check_output("urun_cnt", 32'(urun_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic check_reset();
    check_output("rst_ov", 32'(bus.ov), 32'd0);
    check_output("rst_sos", 32'(bus.sos), 32'd0);
    check_output("rst_eos", 32'(bus.eos), 32'd0);
    check_output("rst_urun", 32'(bus.urun), 32'd0);
    check_output("rst_ready", 32'(bus.ready), 32'd0);
    check_output("rst_wr_full", 32'(bus.wr_full), 32'd0);
    check_output("rst_wr_ovf", 32'(bus.wr_ovf), 32'd0);
    check_output("rst_dox", 32'(bus.dox), 32'd0);
    check_output("rst_doy", 32'(bus.doy), 32'd0);
`ifdef OFDM_CP_UNDERRUN_CNT_EN
    check_output("rst_urun_cnt", 32'(urun_cnt), 32'd0);
`endif
  endtask

  // One clock: reference first, then the DUT edge, then compare.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic apply_reset();
    bus.oe        = 1'b0;
    bus.wr_iv     = 1'b0;
    bus.wr_commit = 1'b0;
    rst = 1'b1;
    #2;
    model_reset();
    check_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // mode 0: x=a, y=-a; mode 1: x=100+a, y random; otherwise fully random.
  // Address bits above N-1 are randomised to exercise the address mask.
  task automatic apply_stimulus(input int n, input int mode);
    for (int a = 0; a < n; a++) begin
      bus.wr_iv   = 1'b1;
      bus.wr_addr = LOGN_MAX'(($urandom_range(0, NMAX - 1) & ~(n - 1)) | a);
      case (mode)
        0: begin
          bus.wr_x = DW'(a);
          bus.wr_y = DW'(-a);
        end
        1: begin
          bus.wr_x = DW'(100 + a);
          bus.wr_y = DW'($urandom);
        end
        default: begin
          bus.wr_x = DW'($urandom);
          bus.wr_y = DW'($urandom);
        end
      endcase
      tick();
    end
    bus.wr_iv = 1'b0;
  endtask

  task automatic commit();
    bus.wr_commit = 1'b1;
    tick();
    bus.wr_commit = 1'b0;
  endtask

  task automatic oe_run(input int count, input int gap);
    for (int i = 0; i < count; i++) begin
      bus.oe = 1'b1;
      tick();
      bus.oe = 1'b0;
      repeat (gap) tick();
    end
  endtask

  initial begin
    rst           = 1'b0;
    bus.cfg_logn  = 4'd5;
    bus.cfg_cp    = 8'd8;
    bus.wr_iv     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_x      = '0;
    bus.wr_y      = '0;
    bus.wr_commit = 1'b0;
    bus.oe        = 1'b0;
`ifdef OFDM_CP_UNDERRUN_CNT_EN
    urun_clr      = 1'b0;
`endif
    #1;
    apply_reset();

    $display("[TB] basic framing N=32 CP=8");
    apply_stimulus(32, 0);
    commit();
    for (int k = 0; k < 40; k++) begin
      bus.oe = 1'b1;
      tick();
      bus.oe = 1'b0;
      check_output("t1_seq", 32'(bus.dox), 32'((k < 8) ? 24 + k : k - 8));
      repeat (7) tick();
    end

    $display("[TB] gapless ping-pong");
    apply_stimulus(32, 0);
    commit();
    apply_stimulus(32, 1);
    commit();
    bus.oe = 1'b1;
    repeat (80) tick();
    bus.oe = 1'b0;
    tick();

    $display("[TB] overflow and readback");
    apply_stimulus(32, 2);
    commit();
    apply_stimulus(32, 2);
    commit();
    commit();
    apply_stimulus(32, 2);
    oe_run(80, 0);

    $display("[TB] underrun and reset");
    oe_run(3, 2);
    check_output("t4_urun", 32'(bus.urun), 32'd0);
    apply_stimulus(32, 2);
    commit();
    oe_run(10, 3);
    apply_reset();
    bus.oe = 1'b1;
    tick();
    bus.oe = 1'b0;
    check_output("t4_post_rst_urun", 32'(bus.urun), 32'd1);
    tick();

    $display("[TB] size and prefix clamping");
    bus.cfg_logn = 4'd3;
    bus.cfg_cp   = 8'd200;
    apply_stimulus(32, 2);
    commit();
    oe_run(20, 0);
    bus.cfg_logn = 4'd6;
    bus.cfg_cp   = 8'd4;
    bus.oe = 1'b1;
    apply_stimulus(64, 2);
    commit();
    repeat (75) tick();
    bus.oe = 1'b0;
    tick();

`ifdef OFDM_CP_UNDERRUN_CNT_EN
    $display("[TB] underrun counter");
    bus.cfg_logn = 4'd5;
    bus.cfg_cp   = 8'd8;
    apply_reset();
    oe_run(3, 1);
    commit();
    commit();
    commit();
    check_output("t6_cnt4", 32'(urun_cnt), 32'd4);
    oe_run(80, 0);
    bus.oe   = 1'b1;
    urun_clr = 1'b1;
    tick();
    bus.oe   = 1'b0;
    urun_clr = 1'b0;
    check_output("t6_cnt0", 32'(urun_cnt), 32'd0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ofdm_cp_pingpong_buf.md
Name: ofdm_cp_pingpong_buf

Overview:
- Parametrised transmit-side symbol buffer placed between the IFFT engine output and the DAC/upsampler.
- Two symbol banks are used in ping-pong: the IFFT writes one bank by address while the other is read out in natural order.
- Each symbol is preceded by a runtime-programmable cyclic prefix, with a runtime FFT size of 32..2^LOGN_MAX.
- Compared with the fixed 256-point buffer it generalises sample width and depth, and adds double buffering, underrun/overflow signalling and symbol framing strobes.

Parameters:
- DW, 16, sample width per I/Q component (signed two's complement).
- LOGN_MAX, 8, log2 of the largest FFT size; bank depth = 2^LOGN_MAX.
- CPW, 8, width of the cyclic-prefix length field.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_logn  in  4  log2 FFT size; legal range 5..LOGN_MAX, clamped into it.
- cfg_cp  in  CPW  cyclic-prefix length in samples; clamped to N.
- wr_iv  in  1  write strobe for one IFFT output sample.
- wr_addr  in  LOGN_MAX  bin/time index; only the low cfg_logn bits are used.
- wr_x, wr_y  in  DW each  I/Q sample to write.
- wr_commit  in  1  marks the current write bank complete.
- wr_full  out  1  both banks hold unread symbols.
- wr_ovf  out  1  one-cycle pulse when a commit is rejected.
- oe  in  1  output strobe, one sample per assertion, any cadence.
- dox, doy  out  DW each  output sample.
- ov  out  1  output valid, one cycle after oe.
- sos  out  1  qualifies ov; marks the first prefix sample of a symbol.
- eos  out  1  qualifies ov; marks the last sample of a symbol.
- urun  out  1  qualifies ov; marks a zero sample emitted because no bank was ready.
- ready  out  1  at least one bank is full.

Behaviour:
- Reset values: all outputs 0; full[1:0]=0; wbank=0; rbank=0; pos=0; state IDLE.
- Storage: 2 x 2^LOGN_MAX words of 2*DW bits, synchronous read with 1-cycle latency.

Write side:
- wr_iv writes {wr_x, wr_y} to bank wbank at wr_addr masked to N-1.
- A write to a bank that is full is dropped.
- wr_commit with full[wbank]=0 sets full[wbank] and toggles wbank.
- wr_commit with full[wbank]=1 is rejected: wr_ovf pulses and state is unchanged.
- If a bank is released in the same cycle, the commit is evaluated against the post-release state, so it is accepted.
- wr_iv and wr_commit in the same cycle: the write lands before the toggle.

Read FSM, states IDLE and RUN:
- IDLE with oe and full[rbank]=1:
  - latch N=2^clamp(cfg_logn) and CP=min(cfg_cp,N);
  - pos=0; go to RUN; this sample is the first read.
- IDLE with oe and full[rbank]=0: ov=1, dox=doy=0, urun=1 on the next cycle.
- RUN, on each oe:
  - read address = (N-CP+pos) mod N;
  - pos increments;
  - sos is asserted for pos=0, eos for pos=N+CP-1.
  - With CP=0, sos and eos coincide only when N+CP=1, which cannot occur; sos is then simply on address 0.
- At the last sample:
  - clear full[rbank] and toggle rbank on the same edge;
  - if the other bank is full, the next oe starts a new symbol directly, giving a gapless stream;
  - otherwise return to IDLE.
- cfg_* changes take effect only at a symbol start; mid-symbol changes are ignored.
- oe never stalls, and ov follows oe with fixed 1-cycle latency regardless of state.
- ready = |full.
- wr_full = &full, registered with the same-edge update.
- Reset mid-symbol discards both banks; the first oe after reset produces an urun sample.

Optional Feature:
- Macro: OFDM_CP_UNDERRUN_CNT_EN.
- When defined:
  - adds output urun_cnt [15:0], a saturating count of urun samples plus rejected commits;
  - adds input urun_clr, which zeroes the count (clear wins over a simultaneous increment);
  - reset value 0.
- When undefined, the ports and the counter are absent and there is no other behavioural difference.

Decomposition:
- Shared package ofdm_pkg holds:
  - LOGN_MIN=5 constant;
  - rd_state_t enum {IDLE, RUN};
  - the clamp function for logn/CP;
  - the sample struct {x, y}.
- One sub-module, ofdm_dpram (simple dual-port RAM, parametrised width/depth, registered read), is instantiated once with depth 2^(LOGN_MAX+1) and bank select as the address MSB.

Test Plan:
1. Basic framing:
   - Stimulus: cfg_logn=5, cfg_cp=8; write bank0 with x=addr, y=-addr; commit; 40 oe strobes every 8 cycles.
   - Expect: dox sequence 24..31, then 0..31; sos on the first, eos on the 40th; ready falls after eos.
2. Gapless ping-pong:
   - Stimulus: fill and commit both banks (x=addr and x=100+addr); oe held high for 80 cycles.
   - Expect: 80 consecutive ov; bank1 samples follow bank0 with no urun; wr_full=1 until the first eos.
3. Overflow:
   - Stimulus: commit three times with no reads.
   - Expect: the third commit gives one wr_ovf pulse, full stays 2'b11, and bank contents are unchanged on readback.
4. Underrun and reset:
   - Stimulus: oe with no committed bank, then assert rst mid-symbol in scenario 1.
   - Expect: dox=doy=0 with urun=1; after reset all outputs are 0, and the next oe gives urun.
5. Size/CP clamping:
   - Stimulus: cfg_logn=3, cfg_cp=200, LOGN_MAX=8; then change cfg to 6/4 mid-symbol.
   - Expect: N=32, CP=32 (64 samples/symbol); the new configuration applies only at the next sos.
6. With OFDM_CP_UNDERRUN_CNT_EN:
   - Stimulus: 3 urun samples plus 1 rejected commit, then urun_clr coinciding with a urun.
   - Expect: urun_cnt=4, then 0.
